// File: rtl/uart_alu_responder.sv
// Device-side request/response engine: collects A, B and opcode bytes from the
// receiver, evaluates them in a small ALU and hands one result byte to the transmitter.
module uart_alu_responder #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 25000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_tx_ready,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_valid,
    output logic               o_busy,
    output logic               o_error
);

    // state  | meaning
    // GET_A  | waiting for operand A (no timeout)
    // GET_B  | waiting for operand B (timed)
    // GET_OP | waiting for opcode (timed)
    // EXEC   | one cycle: register ALU result
    // SEND   | hold result until the transmitter is ready
    localparam logic [2:0] ST_GET_A  = 3'd0;
    localparam logic [2:0] ST_GET_B  = 3'd1;
    localparam logic [2:0] ST_GET_OP = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_SEND   = 3'd4;

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA'(NB_DATA);

    logic [2:0]         state_q,  state_d;
    logic [NB_DATA-1:0] a_q,      a_d;
    logic [NB_DATA-1:0] b_q,      b_d;
    logic [NB_OP-1:0]   op_q,     op_d;
    logic [NB_DATA-1:0] result_q, result_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;

    logic [NB_DATA-1:0] alu_res;
    logic               op_known;
    logic               timeout_fire;

    always_comb begin
        alu_res  = '0;
        op_known = 1'b1;
        case (op_q)
            OP_ADD: alu_res = a_q + b_q;
            OP_SUB: alu_res = a_q - b_q;
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_NOR: alu_res = ~(a_q | b_q);
            OP_SRA: begin
                if (b_q >= SHIFT_LIMIT) begin
                    alu_res = {NB_DATA{a_q[NB_DATA-1]}};
                end else begin
                    alu_res = $unsigned($signed(a_q) >>> b_q);
                end
            end
            OP_SRL: alu_res = a_q >> b_q;
            default: op_known = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        result_d     = result_q;
        cnt_d        = cnt_q;
        timeout_fire = 1'b0;
        case (state_q)
            ST_GET_A: begin
                cnt_d = '0;
                if (i_rx_valid) begin
                    a_d     = i_rx_data;
                    state_d = ST_GET_B;
                end
            end
            ST_GET_B, ST_GET_OP: begin
                // A byte arriving in the expiry cycle is taken; the timeout loses.
                if (i_rx_valid) begin
                    cnt_d = '0;
                    if (state_q == ST_GET_B) begin
                        b_d     = i_rx_data;
                        state_d = ST_GET_OP;
                    end else begin
                        op_d    = i_rx_data[NB_OP-1:0];
                        state_d = ST_EXEC;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    timeout_fire = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_GET_A;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_EXEC: begin
                result_d = alu_res;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (i_tx_ready) begin
                    state_d = ST_GET_A;
                end
            end
            default: state_d = ST_GET_A;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_GET_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    // Pulses are gated by reset so a reset landing in SEND never leaks a transfer.
    assign o_tx_data  = result_q;
    assign o_tx_valid = !i_reset && (state_q == ST_SEND) && i_tx_ready;
    assign o_busy     = (state_q == ST_EXEC) || (state_q == ST_SEND);
    assign o_error    = !i_reset && (timeout_fire || ((state_q == ST_EXEC) && !op_known));

endmodule
